// File: rtl/store_unit_pkg.sv
// Shared datapath codes for the load/store units.
//   - load-select size codes (consumed by the load-data selector)
//   - store size codes, store FSM states, store byte-width masks
package store_unit_pkg;

  // Load-select codes (load-data selector side).
  typedef enum logic [2:0] {
    LD_LW  = 3'b000,
    LD_LH  = 3'b001,
    LD_LB  = 3'b010,
    LD_LHU = 3'b101,
    LD_LBU = 3'b110
  } ld_size_e;

  // Store width codes; any other encoding is illegal.
  typedef enum logic [2:0] {
    SZ_SW = 3'b000,
    SZ_SH = 3'b001,
    SZ_SB = 3'b010
  } st_size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } st_state_e;

  // Byte-enable pattern of each store width before lane shifting.
  localparam logic [3:0] MASK_W = 4'b1111;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_B = 4'b0001;

endpackage

// File: rtl/store_align.sv
// Combinational lane aligner for stores.
//   data    : rs2 store data, lane 0 = LSB
//   size    : store width code (SW/SH/SB)
//   off     : byte offset within the word (addr[1:0])
//   d       : 64-bit shifted data; [31:0] = first word, [63:32] = spill word
//   s       : 8-bit shifted strobes; [3:0] first word, [7:4] spill word
//   illegal : size code is not SW/SH/SB
module store_align
  import store_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]   data,
  input  logic [2:0]        size,
  input  logic [1:0]        off,
  output logic [2*XLEN-1:0] d,
  output logic [7:0]        s,
  output logic              illegal
);

  localparam int NUM_LANES = XLEN / 8;

  logic [3:0]                  mask;
  logic [NUM_LANES-1:0][7:0]   masked;

  always_comb begin
    mask    = 4'b0000;
    illegal = 1'b0;
    case (size)
      SZ_SW:   mask = MASK_W;
      SZ_SH:   mask = MASK_H;
      SZ_SB:   mask = MASK_B;
      default: illegal = 1'b1;
    endcase
  end

  // Bytes outside the width are zeroed so nothing stray lands in the
  // spill word or in disabled lanes.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign masked[i] = mask[i] ? data[i*8 +: 8] : 8'h00;
  end

  assign d = {{XLEN{1'b0}}, masked} << {off, 3'b000};
  assign s = {4'b0000, mask} << off;

endmodule

// File: rtl/store_unit.sv
// Store unit: lane-aligns a store request and drives the data-memory write
// port through valid/ready. Word-crossing stores become two aligned beats
// (or an err pulse when ALLOW_MISALIGNED=0).
//   clk, rst_n          : clock, async active-low reset
//   req_valid/req_ready : request handshake (ready only in IDLE)
//   req_addr/data/size  : byte address, rs2 data, width code
//   mem_valid/mem_ready : write-beat handshake
//   mem_addr/wdata/wstrb: word-aligned address, aligned data, byte enables
//   busy                : request in flight
//   err                 : 1-cycle pulse after accepting an unservable request
module store_unit
  import store_unit_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_data,
  input  logic [2:0]      req_size,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  output logic            busy,
  output logic            err
);

  st_state_e         state, state_nxt;
  logic [2*XLEN-1:0] d;
  logic [7:0]        s;
  logic              illegal;
  logic [XLEN-1:0]   hi_data;
  logic [3:0]        hi_strb;
  logic              accept, reject;
  logic              load_lo, load_hi, vld_nxt, err_nxt;

  store_align #(.XLEN(XLEN)) u_align (
    .data    (req_data),
    .size    (req_size),
    .off     (req_addr[1:0]),
    .d       (d),
    .s       (s),
    .illegal (illegal)
  );

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_valid & req_ready;
  assign reject    = illegal | (!ALLOW_MISALIGNED && (s[7:4] != 4'b0000));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_lo   = 1'b0;
    load_hi   = 1'b0;
    vld_nxt   = mem_valid;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (reject) begin
            err_nxt = 1'b1;
          end else begin
            load_lo   = 1'b1;
            vld_nxt   = 1'b1;
            state_nxt = BEAT0;
          end
        end
      end
      BEAT0: begin
        if (mem_ready) begin
          if (hi_strb != 4'b0000) begin
            load_hi   = 1'b1;
            state_nxt = BEAT1;
          end else begin
            vld_nxt   = 1'b0;
            state_nxt = IDLE;
          end
        end
      end
      BEAT1: begin
        if (mem_ready) begin
          vld_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        vld_nxt   = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= 4'b0000;
      hi_data   <= '0;
      hi_strb   <= 4'b0000;
      err       <= 1'b0;
    end else begin
      mem_valid <= vld_nxt;
      err       <= err_nxt;
      if (load_lo) begin
        mem_addr  <= {req_addr[XLEN-1:2], 2'b00};
        mem_wdata <= d[XLEN-1:0];
        mem_wstrb <= s[3:0];
        hi_data   <= d[2*XLEN-1:XLEN];
        hi_strb   <= s[7:4];
      end else if (load_hi) begin
        // Spill word: next aligned address, wrapping at the top of memory.
        mem_addr  <= mem_addr + XLEN'(4);
        mem_wdata <= hi_data;
        mem_wstrb <= hi_strb;
      end
    end
  end

endmodule
